// File: rtl/heap_pq.sv
// heap_pq: binary-heap priority queue (max- or min-ordered), one heap level sifted per clock.
// Latency: push_ack/pop_ack pulse the cycle after a request is sampled; busy for at most ceil(log2(DEPTH))+1 cycles after that.
// Backpressure: requests are only sampled while idle (busy=0); nothing is queued, so a requester retries until it sees an ack.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   flush                   synchronous clear (count->0, back to idle), beats every request
//   push_req/push_data      insert request and element
//   pop_req                 remove-root request
//   push_ack, pop_ack       one-cycle accept pulses; pop_data holds the removed root
//   top_valid/top_data      root element, valid when idle and non-empty
//   count/full/empty/busy   occupancy and sifter status
//
// Optional feature: define HEAP_PQ_REPLACE_EN so that push_req & pop_req together
// replace the root in one operation instead of letting the pop win.
module heap_pq #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int MIN_HEAP = 0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push_req,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop_req,
  output logic                       push_ack,
  output logic                       pop_ack,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       top_valid,
  output logic [DATA_W-1:0]          top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       busy
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CW     = CNT_W + 1;       // wide enough for 2*cur+2
  localparam int HEAP_N = 1 << IDX_W;      // every IDX_W-bit index is a legal read

`ifdef HEAP_PQ_REPLACE_EN
  localparam bit REPLACE_EN = 1'b1;
`else
  localparam bit REPLACE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [IDX_W-1:0]  cur, cur_nxt;
  logic              push_ack_nxt, pop_ack_nxt;
  logic [DATA_W-1:0] pop_data_nxt;

  logic [DATA_W-1:0] heap [HEAP_N];

  // Two write ports: a swap writes both nodes in the same cycle.
  logic              we_a, we_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [DATA_W-1:0] dat_a, dat_b;

  // "a should sit above b"; equal keys never count as better, so they never swap.
  function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (MIN_HEAP != 0) return a < b;
    else               return a > b;
  endfunction

  // Neighbourhood of the current node.
  logic [IDX_W-1:0]  last_idx, par_idx, l_rd, r_rd, best_idx;
  logic [CW-1:0]     l_idx, r_idx;
  logic              l_ok, r_ok;
  logic [DATA_W-1:0] cur_val, par_val, l_val, r_val, best_val;

  assign last_idx = IDX_W'(count - CNT_W'(1));
  assign par_idx  = (cur - IDX_W'(1)) >> 1;
  assign l_idx    = (CW'(cur) << 1) + CW'(1);
  assign r_idx    = l_idx + CW'(1);
  assign l_ok     = l_idx < CW'(count);
  assign r_ok     = r_idx < CW'(count);
  assign l_rd     = IDX_W'(l_idx);
  assign r_rd     = IDX_W'(r_idx);
  assign cur_val  = heap[cur];
  assign par_val  = heap[par_idx];
  assign l_val    = heap[l_rd];
  assign r_val    = heap[r_rd];
  // Left child wins ties; right child only counts when it exists.
  assign best_idx = (r_ok && better(r_val, l_val)) ? r_rd  : l_rd;
  assign best_val = (r_ok && better(r_val, l_val)) ? r_val : l_val;

  // Request decode (meaningful only in IDLE).
  logic do_replace, do_pop, do_push;
  assign do_replace = REPLACE_EN && push_req && pop_req && !empty;
  assign do_pop     = pop_req && !empty && !do_replace;
  assign do_push    = push_req && !full && (REPLACE_EN || !pop_req) && !do_pop && !do_replace;

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    cur_nxt      = cur;
    push_ack_nxt = 1'b0;
    pop_ack_nxt  = 1'b0;
    pop_data_nxt = pop_data;
    we_a         = 1'b0;
    idx_a        = '0;
    dat_a        = '0;
    we_b         = 1'b0;
    idx_b        = '0;
    dat_b        = '0;

    case (state)
      IDLE: begin
        if (do_replace) begin
          pop_data_nxt = heap[0];
          pop_ack_nxt  = 1'b1;
          push_ack_nxt = 1'b1;
          we_a         = 1'b1;
          idx_a        = '0;
          dat_a        = push_data;
          cur_nxt      = '0;
          state_nxt    = SIFT_DOWN;
        end else if (do_pop) begin
          pop_data_nxt = heap[0];
          pop_ack_nxt  = 1'b1;
          we_a         = 1'b1;
          idx_a        = '0;
          dat_a        = heap[last_idx];
          count_nxt    = count - CNT_W'(1);
          cur_nxt      = '0;
          // A heap of zero or one element is already ordered.
          state_nxt    = (count <= CNT_W'(2)) ? IDLE : SIFT_DOWN;
        end else if (do_push) begin
          push_ack_nxt = 1'b1;
          we_a         = 1'b1;
          idx_a        = IDX_W'(count);
          dat_a        = push_data;
          count_nxt    = count + CNT_W'(1);
          cur_nxt      = IDX_W'(count);
          state_nxt    = SIFT_UP;
        end
      end

      SIFT_UP: begin
        if (cur != '0 && better(cur_val, par_val)) begin
          we_a    = 1'b1;
          idx_a   = cur;
          dat_a   = par_val;
          we_b    = 1'b1;
          idx_b   = par_idx;
          dat_b   = cur_val;
          cur_nxt = par_idx;
        end else begin
          state_nxt = IDLE;
        end
      end

      SIFT_DOWN: begin
        if (l_ok && better(best_val, cur_val)) begin
          we_a    = 1'b1;
          idx_a   = cur;
          dat_a   = best_val;
          we_b    = 1'b1;
          idx_b   = best_idx;
          dat_b   = cur_val;
          cur_nxt = best_idx;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    // Flush overrides every request and any sift in flight.
    if (flush) begin
      state_nxt    = IDLE;
      count_nxt    = '0;
      cur_nxt      = '0;
      push_ack_nxt = 1'b0;
      pop_ack_nxt  = 1'b0;
      we_a         = 1'b0;
      we_b         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      cur      <= '0;
      push_ack <= 1'b0;
      pop_ack  <= 1'b0;
      pop_data <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      cur      <= cur_nxt;
      push_ack <= push_ack_nxt;
      pop_ack  <= pop_ack_nxt;
      pop_data <= pop_data_nxt;
    end
  end

  // Element storage has no reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (we_a) heap[idx_a] <= dat_a;
    if (we_b) heap[idx_b] <= dat_b;
  end

  assign busy      = (state != IDLE);
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign top_valid = !busy && !empty;
  assign top_data  = heap[0];

endmodule

// File: tb/tb_heap_pq.sv
// tb_heap_pq: drives a max-heap and a min-heap instance (DEPTH=8) with directed and random commands.
// Expected results come from an unordered multiset per instance: pops return its largest/smallest entry.
// Directed steps cover reset, ordering, duplicates, full/empty, push+pop arbitration and flush mid-sift.
module tb_heap_pq;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int BUSY_MAX = 4;   // ceil(log2(8)) + 1

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    flush_s, push_req_s, pop_req_s;
  logic [1:0]    push_ack_s, pop_ack_s, top_valid_s, full_s, empty_s, busy_s;
  logic [DW-1:0] push_data_s [2];
  logic [DW-1:0] pop_data_s  [2];
  logic [DW-1:0] top_data_s  [2];
  logic [CW-1:0] count_s     [2];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference multisets: index 0 = max-heap instance, 1 = min-heap instance.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  logic [DW-1:0] last_pd;
  logic          last_pa, last_qa;
  int            last_cyc;

  always #5 clk = ~clk;

  heap_pq #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(0)) u_max (
    .clk(clk), .reset_n(reset_n), .flush(flush_s[0]),
    .push_req(push_req_s[0]), .push_data(push_data_s[0]), .pop_req(pop_req_s[0]),
    .push_ack(push_ack_s[0]), .pop_ack(pop_ack_s[0]), .pop_data(pop_data_s[0]),
    .top_valid(top_valid_s[0]), .top_data(top_data_s[0]), .count(count_s[0]),
    .full(full_s[0]), .empty(empty_s[0]), .busy(busy_s[0])
  );

  heap_pq #(.DATA_W(DW), .DEPTH(DEPTH), .MIN_HEAP(1)) u_min (
    .clk(clk), .reset_n(reset_n), .flush(flush_s[1]),
    .push_req(push_req_s[1]), .push_data(push_data_s[1]), .pop_req(pop_req_s[1]),
    .push_ack(push_ack_s[1]), .pop_ack(pop_ack_s[1]), .pop_data(pop_data_s[1]),
    .top_valid(top_valid_s[1]), .top_data(top_data_s[1]), .count(count_s[1]),
    .full(full_s[1]), .empty(empty_s[1]), .busy(busy_s[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Index of the entry a pop should return: largest for sel 0, smallest for sel 1.
  function automatic int best_pos(input int sel, input int n);
    int bi;
    bi = 0;
    for (int i = 1; i < n; i++) begin
      if (sel == 0) begin
        if (q0[i] > q0[bi]) bi = i;
      end else begin
        if (q1[i] < q1[bi]) bi = i;
      end
    end
    return bi;
  endfunction

  function automatic logic [DW-1:0] mdl_best(input int sel);
    int n;
    n = (sel == 0) ? q0.size() : q1.size();
    return (sel == 0) ? q0[best_pos(0, n)] : q1[best_pos(1, n)];
  endfunction

  // One request cycle; acks and pop_data are compared with the multiset outcome.
  task automatic issue(input int sel, input logic pu, input logic [DW-1:0] d, input logic po);
    int n, bi;
    logic exp_pa, exp_qa;
    logic [DW-1:0] exp_pd;
    n      = (sel == 0) ? q0.size() : q1.size();
    exp_pa = 1'b0;
    exp_qa = 1'b0;
    exp_pd = '0;
    if (pu && po) begin
`ifdef HEAP_PQ_REPLACE_EN
      exp_qa = (n > 0);
      exp_pa = 1'b1;
`else
      exp_qa = (n > 0);
`endif
    end else if (po) begin
      exp_qa = (n > 0);
    end else if (pu) begin
      exp_pa = (n < DEPTH);
    end
    if (exp_qa) begin
      bi = best_pos(sel, n);
      if (sel == 0) begin exp_pd = q0[bi]; q0.delete(bi); end
      else          begin exp_pd = q1[bi]; q1.delete(bi); end
    end
    if (exp_pa) begin
      if (sel == 0) q0.push_back(d);
      else          q1.push_back(d);
    end

    push_req_s[sel]  = pu;
    pop_req_s[sel]   = po;
    push_data_s[sel] = d;
    @(posedge clk);
    #1;
    push_req_s[sel] = 1'b0;
    pop_req_s[sel]  = 1'b0;
    last_pa = push_ack_s[sel];
    last_qa = pop_ack_s[sel];
    last_pd = pop_data_s[sel];
    check("push_ack", 32'(last_pa), 32'(exp_pa));
    check("pop_ack", 32'(last_qa), 32'(exp_qa));
    if (exp_qa) check("pop_data", 32'(last_pd), 32'(exp_pd));
  endtask

  // Wait (bounded) for the sifter to go idle, then compare occupancy and root.
  task automatic settle(input int sel);
    int n;
    last_cyc = 0;
    while (busy_s[sel] && last_cyc < 40) begin
      @(posedge clk);
      #1;
      last_cyc++;
    end
    n = (sel == 0) ? q0.size() : q1.size();
    check("busy_bound", 32'(last_cyc <= BUSY_MAX), 32'd1);
    check("count", 32'(count_s[sel]), 32'(n));
    check("empty", 32'(empty_s[sel]), 32'(n == 0));
    check("full", 32'(full_s[sel]), 32'(n == DEPTH));
    check("top_valid", 32'(top_valid_s[sel]), 32'(n != 0));
    if (n != 0) check("top_data", 32'(top_data_s[sel]), 32'(mdl_best(sel)));
  endtask

  task automatic do_flush(input int sel);
    flush_s[sel] = 1'b1;
    @(posedge clk);
    #1;
    flush_s[sel] = 1'b0;
    if (sel == 0) q0.delete();
    else          q1.delete();
    check("flush_count", 32'(count_s[sel]), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    reset_n    = 1'b0;
    flush_s    = '0;
    push_req_s = '0;
    pop_req_s  = '0;
    push_data_s[0] = '0;
    push_data_s[1] = '0;

    // Reset state
    #12;
    for (int s = 0; s < 2; s++) begin
      check("rst_count", 32'(count_s[s]), 32'd0);
      check("rst_empty", 32'(empty_s[s]), 32'd1);
      check("rst_busy", 32'(busy_s[s]), 32'd0);
      check("rst_acks", 32'({push_ack_s[s], pop_ack_s[s]}), 32'd0);
      check("rst_pop_data", 32'(pop_data_s[s]), 32'd0);
      check("rst_top_valid", 32'(top_valid_s[s]), 32'd0);
    end
    #11 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Async reset in the middle of SIFT_DOWN
    issue(0, 1'b1, 16'd3, 1'b0); settle(0);
    issue(0, 1'b1, 16'd1, 1'b0); settle(0);
    issue(0, 1'b1, 16'd2, 1'b0); settle(0);
    issue(0, 1'b1, 16'd4, 1'b0); settle(0);
    issue(0, 1'b0, 16'd0, 1'b1);
    check("t1_busy_before_rst", 32'(busy_s[0]), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t1_rst_count", 32'(count_s[0]), 32'd0);
    check("t1_rst_busy", 32'(busy_s[0]), 32'd0);
    check("t1_rst_empty", 32'(empty_s[0]), 32'd1);
    check("t1_rst_acks", 32'({push_ack_s[0], pop_ack_s[0]}), 32'd0);
    q0.delete();
    q1.delete();
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Max-heap ordering
    issue(0, 1'b1, 16'd5, 1'b0); settle(0);
    issue(0, 1'b1, 16'd9, 1'b0); settle(0);
    issue(0, 1'b1, 16'd1, 1'b0); settle(0);
    issue(0, 1'b1, 16'd7, 1'b0); settle(0);
    check("t2_top", 32'(top_data_s[0]), 32'd9);
    issue(0, 1'b0, 16'd0, 1'b1); check("t2_pop9", 32'(last_pd), 32'd9); settle(0);
    issue(0, 1'b0, 16'd0, 1'b1); check("t2_pop7", 32'(last_pd), 32'd7); settle(0);
    issue(0, 1'b0, 16'd0, 1'b1); check("t2_pop5", 32'(last_pd), 32'd5); settle(0);
    issue(0, 1'b0, 16'd0, 1'b1); check("t2_pop1", 32'(last_pd), 32'd1); settle(0);
    issue(0, 1'b0, 16'd0, 1'b1); check("t2_pop_empty_ack", 32'(last_qa), 32'd0); settle(0);

    // Min-heap with duplicate keys
    issue(1, 1'b1, 16'd30, 1'b0); settle(1);
    issue(1, 1'b1, 16'd10, 1'b0); settle(1);
    issue(1, 1'b1, 16'd20, 1'b0); settle(1);
    issue(1, 1'b1, 16'd10, 1'b0); settle(1);
    // One swap past 30, then the equal root stops the climb: two busy cycles.
    check("t3_dup_busy_cycles", 32'(last_cyc), 32'd2);
    issue(1, 1'b0, 16'd0, 1'b1); check("t3_pop10a", 32'(last_pd), 32'd10); settle(1);
    issue(1, 1'b0, 16'd0, 1'b1); check("t3_pop10b", 32'(last_pd), 32'd10); settle(1);
    issue(1, 1'b0, 16'd0, 1'b1); check("t3_pop20", 32'(last_pd), 32'd20); settle(1);
    issue(1, 1'b0, 16'd0, 1'b1); check("t3_pop30", 32'(last_pd), 32'd30); settle(1);

    // Full boundary
    for (int v = 1; v <= 8; v++) begin
      issue(0, 1'b1, 16'(v), 1'b0);
      settle(0);
    end
    check("t4_full", 32'(full_s[0]), 32'd1);
    issue(0, 1'b1, 16'd99, 1'b0);
    check("t4_push_full_ack", 32'(last_pa), 32'd0);
    settle(0);
    check("t4_count8", 32'(count_s[0]), 32'd8);
    issue(0, 1'b0, 16'd0, 1'b1);
    check("t4_pop8", 32'(last_pd), 32'd8);
    settle(0);
    check("t4_pop_busy", 32'(last_cyc <= 4), 32'd1);

    // Simultaneous push + pop on {9,4}
    do_flush(0);
    issue(0, 1'b1, 16'd9, 1'b0); settle(0);
    issue(0, 1'b1, 16'd4, 1'b0); settle(0);
    issue(0, 1'b1, 16'd50, 1'b1);
    check("t5_pop_ack", 32'(last_qa), 32'd1);
    check("t5_pop_data", 32'(last_pd), 32'd9);
`ifdef HEAP_PQ_REPLACE_EN
    check("t5_push_ack", 32'(last_pa), 32'd1);
    settle(0);
    check("t5_top", 32'(top_data_s[0]), 32'd50);
    check("t5_count", 32'(count_s[0]), 32'd2);
`else
    check("t5_push_ack", 32'(last_pa), 32'd0);
    settle(0);
    check("t5_count", 32'(count_s[0]), 32'd1);
`endif

    // Flush during SIFT_UP
    do_flush(0);
    for (int v = 1; v <= 5; v++) begin
      issue(0, 1'b1, 16'(v * 10), 1'b0);
      settle(0);
    end
    issue(0, 1'b1, 16'd99, 1'b0);
    check("t6_busy_before_flush", 32'(busy_s[0]), 32'd1);
    flush_s[0] = 1'b1;
    @(posedge clk);
    #1;
    flush_s[0] = 1'b0;
    q0.delete();
    check("t6_count", 32'(count_s[0]), 32'd0);
    check("t6_busy", 32'(busy_s[0]), 32'd0);
    check("t6_top_valid", 32'(top_valid_s[0]), 32'd0);

    // Random traffic on both instances, small value range to force duplicates
    for (int s = 0; s < 2; s++) begin
      do_flush(s);
      for (int k = 0; k < 150; k++) begin
        int r;
        r = $urandom_range(0, 9);
        issue(s, (r < 5) || (r >= 8), 16'($urandom_range(0, 15)), (r >= 5));
        settle(s);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
